// File: rtl/urv_fetch_queue.sv
// ============================================================================
// Module   : urv_fetch_queue
// Purpose  : uRV fetch stage with a 2-entry prefetch queue and branch redirect
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module urv_fetch_queue #(
  parameter logic [31:0] g_reset_vector = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_target_i,
  input  logic        f_stall_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  output logic        f_valid_o,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pend_pc;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_tail;
  logic [31:0] r_q_pc [2];
  logic [31:0] r_q_ir [2];

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_count_next;
  logic        w_unused;

  assign w_unused = ^x_target_i[1:0];

  always_comb begin
    w_pop        = (r_count != 2'd0) & ~f_stall_i & ~x_bra_i;
    w_push       = im_valid_i & (r_state == S_WAIT) & ~x_bra_i;
    w_count_next = {1'b0, r_count} + {2'b00, w_push} - {2'b00, w_pop};
    // Only one request may be outstanding, and it must have a free slot to land in.
    w_issue      = ~rst_i & ~x_bra_i & ((r_state == S_IDLE) | im_valid_i) &
                   (w_count_next < 3'd2);
  end

  always_comb begin
    w_state_next = r_state;
    if (x_bra_i) begin
      // A response arriving with the redirect is already stale.
      if (r_state != S_IDLE)
        w_state_next = im_valid_i ? S_IDLE : S_DROP;
    end else if (w_issue) begin
      w_state_next = S_WAIT;
    end else if (im_valid_i && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= g_reset_vector;
      r_pend_pc  <= 32'h0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_q_pc[0]  <= 32'h0;
      r_q_pc[1]  <= 32'h0;
      r_q_ir[0]  <= 32'h0;
      r_q_ir[1]  <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (x_bra_i) begin
        r_count    <= 2'd0;
        r_head     <= 1'b0;
        r_tail     <= 1'b0;
        r_fetch_pc <= {x_target_i[31:2], 2'b00};
      end else begin
        r_count <= w_count_next[1:0];
        if (w_issue) begin
          r_pend_pc  <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_q_pc[r_tail] <= r_pend_pc;
          r_q_ir[r_tail] <= im_data_i;
          r_tail         <= ~r_tail;
        end
        if (w_pop)
          r_head <= ~r_head;
      end
    end
  end

  assign im_addr_o = r_fetch_pc;
  assign im_rd_o   = w_issue;
  assign f_valid_o = (r_count != 2'd0);
  assign f_pc_o    = r_q_pc[r_head];
  assign f_ir_o    = r_q_ir[r_head];

endmodule

`default_nettype wire

// File: tb/tb_urv_fetch_queue.sv
// ============================================================================
// Module   : tb_urv_fetch_queue
// Purpose  : Scenario bench for urv_fetch_queue with a variable-latency memory
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_urv_fetch_queue;

  localparam logic [31:0] c_key = 32'h1357_9BDF;

  logic        clk;
  logic        rst_i;
  logic        x_bra_i;
  logic [31:0] x_target_i;
  logic        f_stall_i;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;
  logic        f_valid_o;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;

  int          n_pass;
  int          n_total;
  int          lat;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  urv_fetch_queue #(.g_reset_vector(32'h0000_0000)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .x_bra_i    (x_bra_i),
    .x_target_i (x_target_i),
    .f_stall_i  (f_stall_i),
    .im_addr_o  (im_addr_o),
    .im_rd_o    (im_rd_o),
    .im_data_i  (im_data_i),
    .im_valid_i (im_valid_i),
    .f_valid_o  (f_valid_o),
    .f_ir_o     (f_ir_o),
    .f_pc_o     (f_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one request in flight, reply after 'lat' cycles, data = addr ^ key.
  initial begin
    logic        pend;
    int          due;
    logic [31:0] addr;
    pend = 1'b0; due = 0; addr = 32'h0;
    im_valid_i = 1'b0;
    im_data_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_i) pend = 1'b0;
      else if (im_rd_o) begin
        pend = 1'b1; due = lat; addr = im_addr_o;
      end
      @(posedge clk); #1;
      im_valid_i = 1'b0;
      if (pend) begin
        due--;
        if (due == 0) begin
          im_valid_i = 1'b1;
          im_data_i  = addr ^ c_key;
          pend       = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    x_bra_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    @(negedge clk);
    n_total++; if (im_rd_o !== 1'b0) $display("FAIL reset_rd got=%b want=0", im_rd_o); else n_pass++;
    n_total++; if (f_valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", f_valid_o); else n_pass++;
    n_total++; if (f_ir_o !== 32'h0) $display("FAIL reset_ir got=%h want=0", f_ir_o); else n_pass++;
    n_total++; if (f_pc_o !== 32'h0) $display("FAIL reset_pc got=%h want=0", f_pc_o); else n_pass++;
    n_total++; if (im_addr_o !== 32'h0) $display("FAIL reset_addr got=%h want=0", im_addr_o); else n_pass++;
  endtask

  task automatic test_stream();
    lat = 1; f_stall_i = 1'b0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k < 10) sb.push_back(32'(4 * k));
      @(negedge clk);
      n_total++;
      if (im_rd_o !== 1'b1 || im_addr_o !== 32'(4 * k))
        $display("FAIL stream_req k=%0d got rd=%b addr=%h want rd=1 addr=%h", k, im_rd_o, im_addr_o, 4 * k);
      else n_pass++;
      n_total++;
      if (f_valid_o !== (k >= 2)) $display("FAIL stream_valid k=%0d got=%b want=%b", k, f_valid_o, k >= 2);
      else n_pass++;
      if (f_valid_o && !f_stall_i && !x_bra_i) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL stream_extra got pc=%h want none", f_pc_o);
        else begin
          exp_pc = sb.pop_front();
          if (f_pc_o !== exp_pc || f_ir_o !== (exp_pc ^ c_key))
            $display("FAIL stream_out got pc=%h ir=%h want pc=%h ir=%h", f_pc_o, f_ir_o, exp_pc, exp_pc ^ c_key);
          else n_pass++;
        end
      end
      tick();
    end
    n_total++; if (sb.size() != 0) $display("FAIL stream_missing got left=%0d want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_stall();
    int n_req;
    lat = 1; f_stall_i = 1'b1; n_req = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (im_rd_o) n_req++;
      if (k >= 2) begin
        n_total++;
        if (f_valid_o !== 1'b1 || f_pc_o !== 32'h0)
          $display("FAIL stall_hold k=%0d got valid=%b pc=%h want valid=1 pc=0", k, f_valid_o, f_pc_o);
        else n_pass++;
      end
      tick();
    end
    n_total++; if (n_req != 2) $display("FAIL stall_requests got=%0d want=2", n_req); else n_pass++;
    f_stall_i = 1'b0;
    for (int k = 0; k < 8; k++) sb.push_back(32'(4 * k));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (f_valid_o && !f_stall_i && !x_bra_i) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL stall_extra got pc=%h want none", f_pc_o);
        else begin
          exp_pc = sb.pop_front();
          if (f_pc_o !== exp_pc || f_ir_o !== (exp_pc ^ c_key))
            $display("FAIL stall_out got pc=%h ir=%h want pc=%h ir=%h", f_pc_o, f_ir_o, exp_pc, exp_pc ^ c_key);
          else n_pass++;
        end
      end
      tick();
    end
    n_total++; if (sb.size() != 0) $display("FAIL stall_missing got left=%0d want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_branch_drop();
    lat = 3; f_stall_i = 1'b0;
    do_reset();
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h100); sb.push_back(32'h104);
    for (int k = 0; k < 17; k++) begin
      x_bra_i    = (k == 8);
      x_target_i = 32'h100;
      @(negedge clk);
      if (k == 8) begin
        n_total++; if (im_rd_o !== 1'b0) $display("FAIL drop_noissue got=%b want=0", im_rd_o); else n_pass++;
      end
      if (k == 9) begin
        n_total++;
        if (im_rd_o !== 1'b1 || im_addr_o !== 32'h100)
          $display("FAIL drop_refetch got rd=%b addr=%h want rd=1 addr=00000100", im_rd_o, im_addr_o);
        else n_pass++;
      end
      if (f_valid_o && !f_stall_i && !x_bra_i) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL drop_extra got pc=%h want none", f_pc_o);
        else begin
          exp_pc = sb.pop_front();
          if (f_pc_o !== exp_pc || f_ir_o !== (exp_pc ^ c_key))
            $display("FAIL drop_out got pc=%h ir=%h want pc=%h ir=%h", f_pc_o, f_ir_o, exp_pc, exp_pc ^ c_key);
          else n_pass++;
        end
      end
      tick();
    end
    x_bra_i = 1'b0;
    n_total++; if (sb.size() != 0) $display("FAIL drop_missing got left=%0d want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_branch_pop();
    lat = 1; f_stall_i = 1'b0;
    do_reset();
    sb.push_back(32'h0); sb.push_back(32'h4);
    sb.push_back(32'h200); sb.push_back(32'h204); sb.push_back(32'h208);
    for (int k = 0; k < 10; k++) begin
      x_bra_i    = (k == 4);
      x_target_i = 32'h203;
      @(negedge clk);
      if (k == 4) begin
        n_total++;
        if (im_rd_o !== 1'b0 || im_valid_i !== 1'b1 || f_valid_o !== 1'b1)
          $display("FAIL bpop_setup got rd=%b mv=%b fv=%b want 0 1 1", im_rd_o, im_valid_i, f_valid_o);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++; if (f_valid_o !== 1'b0) $display("FAIL bpop_empty got=%b want=0", f_valid_o); else n_pass++;
        n_total++;
        if (im_rd_o !== 1'b1 || im_addr_o !== 32'h200)
          $display("FAIL bpop_refetch got rd=%b addr=%h want rd=1 addr=00000200", im_rd_o, im_addr_o);
        else n_pass++;
      end
      if (f_valid_o && !f_stall_i && !x_bra_i) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL bpop_extra got pc=%h want none", f_pc_o);
        else begin
          exp_pc = sb.pop_front();
          if (f_pc_o !== exp_pc || f_ir_o !== (exp_pc ^ c_key))
            $display("FAIL bpop_out got pc=%h ir=%h want pc=%h ir=%h", f_pc_o, f_ir_o, exp_pc, exp_pc ^ c_key);
          else n_pass++;
        end
      end
      tick();
    end
    x_bra_i = 1'b0;
    n_total++; if (sb.size() != 0) $display("FAIL bpop_missing got left=%0d want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    lat = 1; f_stall_i = 1'b0;
    do_reset();
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
    for (int k = 0; k < 6; k++) begin
      x_bra_i    = (k == 0);
      x_target_i = 32'hFFFF_FFFC;
      @(negedge clk);
      if (k == 1) begin
        n_total++;
        if (im_rd_o !== 1'b1 || im_addr_o !== 32'hFFFF_FFFC)
          $display("FAIL wrap_last got rd=%b addr=%h want rd=1 addr=fffffffc", im_rd_o, im_addr_o);
        else n_pass++;
      end
      if (k == 2) begin
        n_total++;
        if (im_rd_o !== 1'b1 || im_addr_o !== 32'h0)
          $display("FAIL wrap_zero got rd=%b addr=%h want rd=1 addr=00000000", im_rd_o, im_addr_o);
        else n_pass++;
      end
      if (f_valid_o && !f_stall_i && !x_bra_i) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL wrap_extra got pc=%h want none", f_pc_o);
        else begin
          exp_pc = sb.pop_front();
          if (f_pc_o !== exp_pc || f_ir_o !== (exp_pc ^ c_key))
            $display("FAIL wrap_out got pc=%h ir=%h want pc=%h ir=%h", f_pc_o, f_ir_o, exp_pc, exp_pc ^ c_key);
          else n_pass++;
        end
      end
      tick();
    end
    x_bra_i = 1'b0;
    n_total++; if (sb.size() != 0) $display("FAIL wrap_missing got left=%0d want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    lat = 1; f_stall_i = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rst_i = (k == 4);
      if (k == 5) begin
        f_stall_i = 1'b0;
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
      end
      @(negedge clk);
      if (k == 3) begin
        n_total++;
        if (f_valid_o !== 1'b1 || f_pc_o !== 32'h0)
          $display("FAIL mid_full got valid=%b pc=%h want valid=1 pc=0", f_valid_o, f_pc_o);
        else n_pass++;
      end
      if (k == 4) begin
        n_total++; if (im_rd_o !== 1'b0) $display("FAIL mid_rst_rd got=%b want=0", im_rd_o); else n_pass++;
      end
      if (k == 5) begin
        n_total++; if (f_valid_o !== 1'b0) $display("FAIL mid_valid got=%b want=0", f_valid_o); else n_pass++;
        n_total++;
        if (im_rd_o !== 1'b1 || im_addr_o !== 32'h0)
          $display("FAIL mid_refetch got rd=%b addr=%h want rd=1 addr=00000000", im_rd_o, im_addr_o);
        else n_pass++;
      end
      if (f_valid_o && !f_stall_i && !x_bra_i && !rst_i) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL mid_extra got pc=%h want none", f_pc_o);
        else begin
          exp_pc = sb.pop_front();
          if (f_pc_o !== exp_pc || f_ir_o !== (exp_pc ^ c_key))
            $display("FAIL mid_out got pc=%h ir=%h want pc=%h ir=%h", f_pc_o, f_ir_o, exp_pc, exp_pc ^ c_key);
          else n_pass++;
        end
      end
      tick();
    end
    n_total++; if (sb.size() != 0) $display("FAIL mid_missing got left=%0d want 0", sb.size()); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; lat = 1;
    rst_i = 1'b1; x_bra_i = 1'b0; x_target_i = 32'h0; f_stall_i = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_drop();
    test_branch_pop();
    test_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
